stopwatch_counter: RTL and testbench
====================================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port count_clk  input  1  count-rate level signal from controller (1 Hz run / 2 Hz adjust), asynchronous to clk.
REQ-004 SHALL have port is_min_increasing  input  1  minutes field enabled.
REQ-005 SHALL have port is_sec_increasing  input  1  seconds field enabled.
REQ-006 SHALL have port clear  input  1  synchronous clear, active-high, level.
REQ-007 SHALL have port min_tens  output  4  BCD minutes tens, 0..9.
REQ-008 SHALL have port min_ones  output  4  BCD minutes ones, 0..9.
REQ-009 SHALL have port sec_tens  output  4  BCD seconds tens, 0..5.
REQ-010 SHALL have port sec_ones  output  4  BCD seconds ones, 0..9.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse when run-mode count leaves 99:59.
REQ-012 SHALL have port overflow  output  1  sticky saturation flag (see Configuration).

Function
REQ-013 SHALL pass count_clk through a two-flop synchronizer, then a third flop holding the previous synchronized value.
REQ-014 SHALL form step = sync2 AND NOT prev; one step per count_clk rising edge, exactly one clk wide.
REQ-015 SHALL update digits on the clk edge where step=1; count_clk rise to visible digit change = 3 clk edges.
REQ-016 Mode by {is_min_increasing, is_sec_increasing}: 00 hold; 11 run; 10 adjust-minutes; 01 adjust-seconds; modes sampled on the step cycle.
REQ-017 Run: seconds +1; sec 59->00 carries +1 into minutes; BCD ones 9->0 carries into tens.
REQ-018 Run at 99:59 (no macro): next step -> 00:00 and wrap=1 for that one cycle.
REQ-019 Adjust-minutes: minutes +1 with no carry from seconds; 99->00 wraps; seconds unchanged; wrap stays 0.
REQ-020 Adjust-seconds: seconds +1; 59->00 wraps without carry into minutes; minutes unchanged; wrap stays 0.
REQ-021 Hold: digits and flags unchanged; steps discarded, not queued.
REQ-022 clear=1: digits -> 00:00, wrap=0, overflow=0 on the next edge; clear beats a simultaneous step.
REQ-023 Synchronizer flops keep running during clear and hold, so no spurious step appears when these release.
REQ-024 Digits SHALL never leave the legal BCD ranges of REQ-007..010, in every mode.

Reset
REQ-025 rst_n=0 SHALL immediately force all digits to 0, wrap=0, overflow=0, sync1/sync2/prev=0.
REQ-026 Reset mid-count SHALL drop any pending step; the first step after release needs a fresh count_clk rise.
REQ-027 If count_clk is already high at release, SHALL produce one step 3 edges after release (prev resets to 0).

Configuration
REQ-028 Macro STOPWATCH_SATURATE_EN SHALL select run-mode behaviour at 99:59.
REQ-029 With STOPWATCH_SATURATE_EN: run-mode step at 99:59 holds 99:59, sets overflow=1 (sticky until clear/reset), wrap stays 0; adjust modes still wrap per REQ-019/020.
REQ-030 Without STOPWATCH_SATURATE_EN: REQ-018 applies; overflow tied to 0.

Verification
REQ-031 Run, 61 count_clk rises from 00:00 -> 01:01; each digit change exactly 3 clk edges after its rise.
REQ-032 Preload 99:58 via run steps, 2 rises -> no macro: 00:00 with one-cycle wrap; macro: 99:59, overflow=1, wrap=0.
REQ-033 Adjust-seconds at 00:59, 1 rise -> 00:00, minutes stay 00; adjust-minutes at 99:30, 1 rise -> 00:30.
REQ-034 Hold (00) at 12:34, 5 rises, then run 1 rise -> 12:35 (no queued steps).
REQ-035 clear asserted on the step cycle at 05:05 -> 00:00, not 00:01; overflow cleared.
REQ-036 rst_n low mid-count at 03:17 -> all outputs 0 immediately; count_clk high at release -> 00:01 after 3 edges.

Source files
------------

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch stepped by rising edges of async count_clk; STOPWATCH_SATURATE_EN makes run mode saturate at 99:59.
// Latency: count_clk rise to digit change = 3 clk edges; no backpressure, steps arriving in hold are dropped.
module stopwatch_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       count_clk,
   input  logic       is_min_increasing,
   input  logic       is_sec_increasing,
   input  logic       clear,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       wrap,
   output logic       overflow
);

   logic       sync1_q, sync2_q, prev_q;
   logic       step;
   logic [3:0] mt_q, mo_q, st_q, so_q;
   logic [3:0] mt_d, mo_d, st_d, so_d;
   logic [3:0] sec_t_inc, sec_o_inc, min_t_inc, min_o_inc;
   logic       sec_max, min_max;
   logic       wrap_q, wrap_d;
   logic       ovf_q, ovf_d;

   assign step    = sync2_q & ~prev_q;
   assign sec_max = (st_q >= 4'd5) && (so_q >= 4'd9);
   assign min_max = (mt_q >= 4'd9) && (mo_q >= 4'd9);

   // Wrapped field increments; >= comparisons pull any stray code back into range.
   always_comb begin
      sec_o_inc = (so_q >= 4'd9) ? 4'd0 : so_q + 4'd1;
      sec_t_inc = st_q;
      if (so_q >= 4'd9) begin
         sec_t_inc = (st_q >= 4'd5) ? 4'd0 : st_q + 4'd1;
      end
      min_o_inc = (mo_q >= 4'd9) ? 4'd0 : mo_q + 4'd1;
      min_t_inc = mt_q;
      if (mo_q >= 4'd9) begin
         min_t_inc = (mt_q >= 4'd9) ? 4'd0 : mt_q + 4'd1;
      end
   end

   always_comb begin
      mt_d   = mt_q;
      mo_d   = mo_q;
      st_d   = st_q;
      so_d   = so_q;
      wrap_d = 1'b0;
      ovf_d  = ovf_q;
      if (clear) begin
         mt_d  = 4'd0;
         mo_d  = 4'd0;
         st_d  = 4'd0;
         so_d  = 4'd0;
         ovf_d = 1'b0;
      end else if (step) begin
         case ({is_min_increasing, is_sec_increasing})
            2'b11: begin
               if (sec_max && min_max) begin
`ifdef STOPWATCH_SATURATE_EN
                  ovf_d = 1'b1;
`else
                  mt_d   = 4'd0;
                  mo_d   = 4'd0;
                  st_d   = 4'd0;
                  so_d   = 4'd0;
                  wrap_d = 1'b1;
`endif
               end else begin
                  st_d = sec_t_inc;
                  so_d = sec_o_inc;
                  if (sec_max) begin
                     mt_d = min_t_inc;
                     mo_d = min_o_inc;
                  end
               end
            end
            2'b10: begin
               mt_d = min_t_inc;
               mo_d = min_o_inc;
            end
            2'b01: begin
               st_d = sec_t_inc;
               so_d = sec_o_inc;
            end
            default: ;
         endcase
      end
   end

   // Synchronizer runs regardless of clear or mode so a held-high count_clk never re-steps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         mt_q    <= 4'd0;
         mo_q    <= 4'd0;
         st_q    <= 4'd0;
         so_q    <= 4'd0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sync1_q <= count_clk;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         mt_q    <= mt_d;
         mo_q    <= mo_d;
         st_q    <= st_d;
         so_q    <= so_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign min_tens = mt_q;
   assign min_ones = mo_q;
   assign sec_tens = st_q;
   assign sec_ones = so_q;
   assign wrap     = wrap_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: an integer minutes/seconds model pushes expected displays per count_clk rise.
module tb_stopwatch_counter;

   typedef struct packed {
      logic [3:0] mt;
      logic [3:0] mo;
      logic [3:0] st;
      logic [3:0] so;
      logic       wr;
      logic       ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       count_clk = 1'b0;
   logic       is_min_increasing = 1'b0;
   logic       is_sec_increasing = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       wrap, overflow;

   int   n_checks = 0;
   int   n_pass = 0;
   int   m_m = 0;
   int   m_s = 0;
   bit   m_ov = 1'b0;
   exp_t shown;
   exp_t sb[$];

   stopwatch_counter dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .count_clk         (count_clk),
      .is_min_increasing (is_min_increasing),
      .is_sec_increasing (is_sec_increasing),
      .clear             (clear),
      .min_tens          (min_tens),
      .min_ones          (min_ones),
      .sec_tens          (sec_tens),
      .sec_ones          (sec_ones),
      .wrap              (wrap),
      .overflow          (overflow)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input int m, input int s, input bit w, input bit o);
      exp_t e;
      e.mt = 4'(m / 10);
      e.mo = 4'(m % 10);
      e.st = 4'(s / 10);
      e.so = 4'(s % 10);
      e.wr = w;
      e.ov = o;
      return e;
   endfunction

   function automatic exp_t obs();
      return {min_tens, min_ones, sec_tens, sec_ones, wrap, overflow};
   endfunction

   task automatic set_mode(input bit mi, input bit si);
      is_min_increasing = mi;
      is_sec_increasing = si;
   endtask

   // One count_clk rise: model step, push expectation, pop and compare on the 3rd clk edge.
   task automatic rise(input bit detailed, input string tag);
      exp_t e, got;
      bit   w;
      int   tot;
      w = 1'b0;
      case ({is_min_increasing, is_sec_increasing})
         2'b11: begin
            if (m_m == 99 && m_s == 59) begin
`ifdef STOPWATCH_SATURATE_EN
               m_ov = 1'b1;
`else
               m_m = 0;
               m_s = 0;
               w   = 1'b1;
`endif
            end else begin
               tot = m_m * 60 + m_s + 1;
               m_m = tot / 60;
               m_s = tot % 60;
            end
         end
         2'b10: m_m = (m_m + 1) % 100;
         2'b01: m_s = (m_s + 1) % 60;
         default: ;
      endcase
      sb.push_back(mk(m_m, m_s, w, m_ov));
      count_clk = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1;
         if (detailed && k < 3) begin
            got = obs();
            n_checks++;
            if (got !== shown)
               $display("FAIL %s early_edge%0d: got %h%h:%h%h w=%b o=%b, expected %h%h:%h%h w=%b o=%b",
                        tag, k, got.mt, got.mo, got.st, got.so, got.wr, got.ov,
                        shown.mt, shown.mo, shown.st, shown.so, shown.wr, shown.ov);
            else n_pass++;
         end
      end
      e   = sb.pop_front();
      got = obs();
      n_checks++;
      if (got !== e)
         $display("FAIL %s edge3: got %h%h:%h%h w=%b o=%b, expected %h%h:%h%h w=%b o=%b",
                  tag, got.mt, got.mo, got.st, got.so, got.wr, got.ov,
                  e.mt, e.mo, e.st, e.so, e.wr, e.ov);
      else n_pass++;
      shown    = e;
      shown.wr = 1'b0;
      @(negedge clk);
      count_clk = 1'b0;
      @(posedge clk);
      #1;
      if (detailed) begin
         got = obs();
         n_checks++;
         if (got !== shown)
            $display("FAIL %s edge4 (wrap one cycle): got %h%h:%h%h w=%b o=%b, expected w=0",
                     tag, got.mt, got.mo, got.st, got.so, got.wr, got.ov);
         else n_pass++;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_time(input int m, input int s);
      set_mode(1'b1, 1'b0);
      while (m_m != m) rise(1'b0, "preload_min");
      set_mode(1'b0, 1'b1);
      while (m_s != s) rise(1'b0, "preload_sec");
   endtask

   task automatic do_clear();
      exp_t e, got;
      clear = 1'b1;
      m_m = 0; m_s = 0; m_ov = 1'b0;
      sb.push_back(mk(0, 0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      got = obs();
      n_checks++;
      if (got !== e) $display("FAIL clear: got %h, expected %h", got, e);
      else n_pass++;
      shown = e;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      exp_t got;
      rst_n = 1'b0;
      #1;
      got = obs();
      n_checks++;
      if (got !== mk(0, 0, 1'b0, 1'b0)) $display("FAIL reset_immediate: got %h, expected 0", got);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      got = obs();
      n_checks++;
      if (got !== mk(0, 0, 1'b0, 1'b0)) $display("FAIL reset_held: got %h, expected 0", got);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      shown = mk(0, 0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      got = obs();
      n_checks++;
      if (got !== mk(0, 0, 1'b0, 1'b0)) $display("FAIL reset_release_idle: got %h, expected 0", got);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_run();
      exp_t got;
      set_mode(1'b1, 1'b1);
      for (int i = 0; i < 61; i++) rise(1'b1, "run");
      got = obs();
      n_checks++;
      if (got !== mk(1, 1, 1'b0, 1'b0)) $display("FAIL run_61: got %h, expected 01:01", got);
      else n_pass++;
   endtask

   task automatic test_wrap();
      exp_t got;
      do_clear();
      set_mode(1'b1, 1'b1);
      while (!(m_m == 99 && m_s == 58)) rise(1'b0, "run_preload");
      rise(1'b1, "run_to_9959");
      rise(1'b1, "run_past_9959");
      got = obs();
      n_checks++;
`ifdef STOPWATCH_SATURATE_EN
      if (got !== mk(99, 59, 1'b0, 1'b1)) $display("FAIL saturate: got %h, expected 99:59 ovf=1", got);
`else
      if (got !== mk(0, 0, 1'b0, 1'b0)) $display("FAIL wrap_end: got %h, expected 00:00", got);
`endif
      else n_pass++;
   endtask

   task automatic test_clear_on_step();
      exp_t e, got;
      set_time(5, 5);
      set_mode(1'b1, 1'b1);
      count_clk = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      clear = 1'b1;
      m_m = 0; m_s = 0; m_ov = 1'b0;
      sb.push_back(mk(0, 0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      got = obs();
      n_checks++;
      if (got !== e) $display("FAIL clear_beats_step: got %h, expected %h", got, e);
      else n_pass++;
      shown = e;
      @(negedge clk);
      clear = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      got = obs();
      n_checks++;
      if (got !== shown) $display("FAIL clear_no_spurious_step: got %h, expected %h", got, shown);
      else n_pass++;
      @(negedge clk);
      count_clk = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_adjust();
      exp_t got;
      do_clear();
      set_time(0, 59);
      set_mode(1'b0, 1'b1);
      rise(1'b1, "adj_sec_wrap");
      got = obs();
      n_checks++;
      if (got !== mk(0, 0, 1'b0, 1'b0)) $display("FAIL adj_sec_wrap: got %h, expected 00:00", got);
      else n_pass++;
      set_time(99, 30);
      set_mode(1'b1, 1'b0);
      rise(1'b1, "adj_min_wrap");
      got = obs();
      n_checks++;
      if (got !== mk(0, 30, 1'b0, 1'b0)) $display("FAIL adj_min_wrap: got %h, expected 00:30", got);
      else n_pass++;
   endtask

   task automatic test_hold();
      exp_t got;
      set_time(12, 34);
      set_mode(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) rise(1'b1, "hold");
      set_mode(1'b1, 1'b1);
      rise(1'b1, "run_after_hold");
      got = obs();
      n_checks++;
      if (got !== mk(12, 35, 1'b0, 1'b0)) $display("FAIL hold_no_queue: got %h, expected 12:35", got);
      else n_pass++;
   endtask

   task automatic test_reset_midcount();
      exp_t e, got;
      set_time(3, 17);
      set_mode(1'b1, 1'b1);
      count_clk = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      got = obs();
      n_checks++;
      if (got !== mk(0, 0, 1'b0, 1'b0)) $display("FAIL reset_midcount_immediate: got %h, expected 0", got);
      else n_pass++;
      sb.delete();
      m_m = 0; m_s = 0; m_ov = 1'b0;
      shown = mk(0, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back(mk(0, 1, 1'b0, 1'b0));
      m_s = 1;
      for (int k = 1; k <= 2; k++) begin
         @(posedge clk);
         #1;
         got = obs();
         n_checks++;
         if (got !== shown) $display("FAIL reset_release_edge%0d: got %h, expected %h", k, got, shown);
         else n_pass++;
      end
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      got = obs();
      n_checks++;
      if (got !== e) $display("FAIL reset_release_step: got %h, expected %h", got, e);
      else n_pass++;
      @(negedge clk);
      count_clk = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_run();
      test_wrap();
      test_clear_on_step();
      test_adjust();
      test_hold();
      test_reset_midcount();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
